// File: rtl/fp16_max_reduce.sv
// Streaming FP16 max/argmax reduction: one {max, index, overflow} result per AXI-Stream packet.
// Optional feature macro FP16_MAX_NAN_PROP_EN: any kept NaN wins the packet as 16'h7E00.
module fp16_max_reduce #(
    parameter int LANES = 4,
    parameter int IDX_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic [16*LANES-1:0] s_tdata,
    input  logic [LANES-1:0]    s_tkeep,
    input  logic                s_tlast,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [15:0]         m_tdata,
    output logic [IDX_W-1:0]    m_tindex,
    output logic                m_tovf
);

`ifdef FP16_MAX_NAN_PROP_EN
    localparam bit NAN_PROP = 1'b1;
`else
    localparam bit NAN_PROP = 1'b0;
`endif

    // Monotonic unsigned key: -inf < -0 < +0 < +inf.
    function automatic logic [15:0] f_key(input logic [15:0] x);
        return x[15] ? ~x : (x ^ 16'h8000);
    endfunction

    function automatic logic f_is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    logic [IDX_W-1:0] r_cnt;
    logic             r_wrap;

    logic             r_a_valid, r_a_last, r_a_any, r_a_nan, r_a_ovf;
    logic [15:0]      r_a_key;
    logic [IDX_W-1:0] r_a_idx;

    logic             r_b_any, r_b_nan;
    logic [15:0]      r_b_key;
    logic [IDX_W-1:0] r_b_idx;

    logic             r_m_valid, r_m_ovf;
    logic [15:0]      r_m_data;
    logic [IDX_W-1:0] r_m_index;

    logic             w_adv, w_accept;
    logic [IDX_W:0]   w_cnt_next, w_beat_end;
    logic             w_any, w_nan;
    logic [15:0]      w_key;
    logic [IDX_W-1:0] w_idx, w_nan_idx;
    logic             w_take_a, w_mg_any, w_mg_nan;
    logic [15:0]      w_mg_key, w_res_data;
    logic [IDX_W-1:0] w_mg_idx, w_res_idx;

    // Stage A only stalls when its last beat cannot enter a full, blocked output register.
    assign w_adv      = !(r_a_valid && r_a_last && r_m_valid && !m_tready);
    assign s_tready   = !rst && w_adv;
    assign w_accept   = s_tvalid && s_tready;
    assign w_cnt_next = {1'b0, r_cnt} + (IDX_W+1)'(LANES);
    assign w_beat_end = {1'b0, r_cnt} + (IDX_W+1)'(LANES - 1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_any     = 1'b0;
        w_nan     = 1'b0;
        w_key     = '0;
        w_idx     = '0;
        w_nan_idx = '0;
        for (int k = 0; k < LANES; k++) begin
            if (s_tkeep[k] && f_is_nan(s_tdata[16*k +: 16])) begin
                if (NAN_PROP && !w_nan) begin
                    w_nan     = 1'b1;
                    w_nan_idx = r_cnt + IDX_W'(k);
                end
            end else if (s_tkeep[k] && (!w_any || f_key(s_tdata[16*k +: 16]) > w_key)) begin
                w_any = 1'b1;
                w_key = f_key(s_tdata[16*k +: 16]);
                w_idx = r_cnt + IDX_W'(k);
            end
        end
    end

    // Stage B keeps the earlier element on equal keys, so ties resolve to the lowest index.
    always_comb begin
        w_take_a = 1'b0;
        if (r_b_nan)
            w_take_a = 1'b0;
        else if (r_a_nan)
            w_take_a = 1'b1;
        else if (r_a_any)
            w_take_a = !r_b_any || (r_a_key > r_b_key);
        w_mg_any = w_take_a ? r_a_any : r_b_any;
        w_mg_nan = w_take_a ? r_a_nan : r_b_nan;
        w_mg_key = w_take_a ? r_a_key : r_b_key;
        w_mg_idx = w_take_a ? r_a_idx : r_b_idx;
        if (w_mg_nan) begin
            w_res_data = 16'h7E00;
            w_res_idx  = w_mg_idx;
        end else if (!w_mg_any) begin
            w_res_data = 16'hFC00;
            w_res_idx  = '1;
        end else begin
            w_res_data = w_mg_key[15] ? (w_mg_key ^ 16'h8000) : ~w_mg_key;
            w_res_idx  = w_mg_idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_wrap    <= 1'b0;
            r_a_valid <= 1'b0;
            r_a_last  <= 1'b0;
            r_a_any   <= 1'b0;
            r_a_nan   <= 1'b0;
            r_a_ovf   <= 1'b0;
            r_a_key   <= '0;
            r_a_idx   <= '0;
            r_b_any   <= 1'b0;
            r_b_nan   <= 1'b0;
            r_b_key   <= '0;
            r_b_idx   <= '0;
            r_m_valid <= 1'b0;
            r_m_ovf   <= 1'b0;
            r_m_data  <= '0;
            r_m_index <= '0;
        end else begin
            if (w_accept) begin
                if (s_tlast) begin
                    r_cnt  <= '0;
                    r_wrap <= 1'b0;
                end else begin
                    r_cnt  <= w_cnt_next[IDX_W-1:0];
                    r_wrap <= r_wrap | w_cnt_next[IDX_W];
                end
            end
            if (w_adv) begin
                r_a_valid <= w_accept;
                if (w_accept) begin
                    r_a_last <= s_tlast;
                    r_a_any  <= w_any;
                    r_a_nan  <= w_nan;
                    r_a_ovf  <= r_wrap | w_beat_end[IDX_W];
                    r_a_key  <= w_key;
                    r_a_idx  <= w_nan ? w_nan_idx : w_idx;
                end
            end
            if (w_adv && r_a_valid) begin
                if (r_a_last) begin
                    r_b_any <= 1'b0;
                    r_b_nan <= 1'b0;
                    r_b_key <= '0;
                    r_b_idx <= '0;
                end else begin
                    r_b_any <= w_mg_any;
                    r_b_nan <= w_mg_nan;
                    r_b_key <= w_mg_key;
                    r_b_idx <= w_mg_idx;
                end
            end
            if (w_adv && r_a_valid && r_a_last) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_res_data;
                r_m_index <= w_res_idx;
                r_m_ovf   <= r_a_ovf;
            end else if (m_tready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_tvalid = r_m_valid;
    assign m_tdata  = r_m_data;
    assign m_tindex = r_m_index;
    assign m_tovf   = r_m_ovf;

endmodule

// File: tb/tb_fp16_max_reduce.sv
// Scoreboard bench for fp16_max_reduce: directed steps plus a short randomised burst.
`timescale 1ns/1ps
module tb_fp16_max_reduce;
    localparam int LANES = 4;
    localparam int IDX_W = 16;
`ifdef FP16_MAX_NAN_PROP_EN
    localparam bit NAN_PROP = 1'b1;
`else
    localparam bit NAN_PROP = 1'b0;
`endif

    typedef struct packed {
        logic [15:0]      data;
        logic [IDX_W-1:0] idx;
        logic             ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid, s_tready, s_tlast;
    logic [63:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        m_tvalid, m_tready, m_tovf;
    logic [15:0] m_tdata;
    logic [15:0] m_tindex;
    logic        rdy_fix, rdy_rand, rand_mode;
    logic        ovf_en, s2_tvalid, s2_tready, m2_tvalid, m2_tovf;
    logic [15:0] m2_tdata;
    logic [3:0]  m2_tindex;

    exp_t        exp_q[$];
    logic [15:0] pk_val[$];
    bit          pk_keep[$];
    bit          use_model;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign m_tready  = rand_mode ? rdy_rand : rdy_fix;
    assign s2_tvalid = s_tvalid & ovf_en;

    always #5 clk = ~clk;

    fp16_max_reduce #(.LANES(LANES), .IDX_W(IDX_W)) u_dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tindex(m_tindex), .m_tovf(m_tovf)
    );

    // Narrow index instance so the element counter wraps within a short packet.
    fp16_max_reduce #(.LANES(LANES), .IDX_W(4)) u_dut_ovf (
        .clk(clk), .rst(rst),
        .s_tvalid(s2_tvalid), .s_tready(s2_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m2_tvalid), .m_tready(1'b1), .m_tdata(m2_tdata), .m_tindex(m2_tindex), .m_tovf(m2_tovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] a0, input logic [15:0] a1,
                                          input logic [15:0] a2, input logic [15:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic bit fp_gt(input logic [15:0] a, input logic [15:0] b);
        if (a[15] != b[15]) return !a[15];
        if (!a[15]) return a[14:0] > b[14:0];
        return a[14:0] < b[14:0];
    endfunction

    function automatic bit fp_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    // Reference result of the elements collected for the current packet.
    function automatic exp_t model_pkt();
        exp_t r;
        bit any = 0;
        bit nan = 0;
        logic [15:0] best = 16'h0;
        int bi = 0;
        for (int i = 0; i < pk_val.size(); i++) begin
            if (pk_keep[i] && !nan) begin
                if (fp_nan(pk_val[i])) begin
                    if (NAN_PROP) begin
                        nan = 1;
                        bi  = i;
                    end
                end else if (!any || fp_gt(pk_val[i], best)) begin
                    any  = 1;
                    best = pk_val[i];
                    bi   = i;
                end
            end
        end
        r.ovf  = 1'b0;
        r.data = nan ? 16'h7E00 : (any ? best : 16'hFC00);
        r.idx  = (nan || any) ? IDX_W'(bi) : '1;
        return r;
    endfunction

    function automatic logic [15:0] rand_fp();
        case ($urandom_range(0, 9))
            0:       return 16'h7C00;
            1:       return 16'hFC00;
            2:       return 16'h0000;
            3:       return 16'h8000;
            4:       return 16'h7E00;
            default: return 16'($urandom());
        endcase
    endfunction

    task automatic push_exp(input logic [15:0] d, input logic [15:0] i, input logic o);
        exp_t e;
        e.data = d;
        e.idx  = i;
        e.ovf  = o;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [63:0] d, input logic [3:0] k, input logic l, output int waits);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            waits++;
            if (waits >= 100) begin
                check("beat_accept", 32'(s_tready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < LANES; i++) begin
            pk_val.push_back(d[16*i +: 16]);
            pk_keep.push_back(k[i]);
        end
        if (l) begin
            if (use_model) exp_q.push_back(model_pkt());
            pk_val.delete();
            pk_keep.delete();
        end
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_s_tready"}, 32'(s_tready), 32'd0);
        check({pfx, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        check({pfx, "_m_tdata"},  32'(m_tdata),  32'd0);
        check({pfx, "_m_tindex"}, 32'(m_tindex), 32'd0);
        check({pfx, "_m_tovf"},   32'(m_tovf),   32'd0);
    endtask

    // Scoreboard: every completed output transfer pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (m_tvalid && m_tready) begin
            check("result_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result_data",  32'(m_tdata),  32'(e.data));
                check("result_index", 32'(m_tindex), 32'(e.idx));
                check("result_ovf",   32'(m_tovf),   32'(e.ovf));
            end
        end
    end

    always @(posedge clk) begin
        #1 rdy_rand = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        rdy_fix = 1'b0; rdy_rand = 1'b0; rand_mode = 1'b0; ovf_en = 1'b0; use_model = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_fix = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(s_tready), 32'd1);

        // Single beat: result visible two cycles after the accepting cycle.
        push_exp(16'h4000, 16'd1, 1'b0);
        drive(pack4(16'h3C00, 16'h4000, 16'hBC00, 16'h3800), 4'hF, 1'b1, w);
        idle();
        @(negedge clk); check("latency_t1_valid", 32'(m_tvalid), 32'd0);
        @(negedge clk); check("latency_t2_valid", 32'(m_tvalid), 32'd1);
        @(posedge clk); #1;

        // Three beats with a tie inside the final beat.
        push_exp(16'h5640, 16'd8, 1'b0);
        drive(pack4(16'h3C00, 16'h4000, 16'h4200, 16'h4400), 4'hF, 1'b0, w);
        drive(pack4(16'h4500, 16'hC000, 16'h4600, 16'h5000), 4'hF, 1'b0, w);
        drive(pack4(16'h5640, 16'h5500, 16'hD640, 16'h5640), 4'hF, 1'b1, w);
        idle();
        wait_drain("drain_tie", 20);

        // Empty packet, signed zeros, and ignored lanes that still consume indices.
        push_exp(16'hFC00, 16'hFFFF, 1'b0);
        drive(pack4(16'h7000, 16'h7000, 16'h7000, 16'h7000), 4'h0, 1'b1, w);
        push_exp(16'h0000, 16'd1, 1'b0);
        drive(pack4(16'h8000, 16'h0000, 16'h0000, 16'h0000), 4'h3, 1'b1, w);
        push_exp(16'h0000, 16'd0, 1'b0);
        drive(pack4(16'h0000, 16'h8000, 16'h0000, 16'h0000), 4'h3, 1'b1, w);
        push_exp(16'h4000, 16'd3, 1'b0);
        drive(pack4(16'h7B00, 16'h3C00, 16'h7A00, 16'h4000), 4'hA, 1'b1, w);
        idle();
        wait_drain("drain_edge", 20);

        // NaN at index 2 followed by +inf in the next beat; then an all-NaN packet.
        if (NAN_PROP) push_exp(16'h7E00, 16'd2, 1'b0);
        else          push_exp(16'h7C00, 16'd4, 1'b0);
        drive(pack4(16'h3C00, 16'h4000, 16'h7C01, 16'h3800), 4'hF, 1'b0, w);
        drive(pack4(16'h7C00, 16'h3C00, 16'h3C00, 16'h3C00), 4'hF, 1'b1, w);
        if (NAN_PROP) push_exp(16'h7E00, 16'd0, 1'b0);
        else          push_exp(16'hFC00, 16'hFFFF, 1'b0);
        drive(pack4(16'hFE00, 16'h7C01, 16'h3C00, 16'h3C00), 4'h3, 1'b1, w);
        idle();
        wait_drain("drain_nan", 20);

        // Back-to-back packets must stream with no wait cycles.
        push_exp(16'h4000, 16'd2, 1'b0);
        push_exp(16'hBC00, 16'd1, 1'b0);
        push_exp(16'h7C00, 16'd0, 1'b0);
        push_exp(16'hFBFF, 16'd1, 1'b0);
        push_exp(16'h4400, 16'd0, 1'b0);
        drive(pack4(16'h3C00, 16'h3C00, 16'h4000, 16'h3C00), 4'hF, 1'b1, w); check("b2b_wait0", 32'(w), 32'd0);
        drive(pack4(16'hC000, 16'hBC00, 16'hC400, 16'hC200), 4'hF, 1'b1, w); check("b2b_wait1", 32'(w), 32'd0);
        drive(pack4(16'h7C00, 16'h7BFF, 16'hFC00, 16'h0000), 4'hF, 1'b1, w); check("b2b_wait2", 32'(w), 32'd0);
        drive(pack4(16'hFC00, 16'hFBFF, 16'hFC00, 16'hFC00), 4'hF, 1'b1, w); check("b2b_wait3", 32'(w), 32'd0);
        drive(pack4(16'h4400, 16'h3C00, 16'h3C00, 16'h3C00), 4'hF, 1'b0, w); check("b2b_wait4", 32'(w), 32'd0);
        drive(pack4(16'h4400, 16'h3C00, 16'h3C00, 16'h3C00), 4'hF, 1'b1, w); check("b2b_wait5", 32'(w), 32'd0);
        idle();
        wait_drain("drain_b2b", 20);

        // Backpressure: two results queued, sink blocked for ten cycles.
        rdy_fix = 1'b0;
        push_exp(16'h4400, 16'd3, 1'b0);
        push_exp(16'h4800, 16'd0, 1'b0);
        drive(pack4(16'h3C00, 16'h4000, 16'h4200, 16'h4400), 4'hF, 1'b1, w);
        drive(pack4(16'h4800, 16'h4600, 16'h4500, 16'h4400), 4'hF, 1'b1, w);
        check("bp_second_wait", 32'(w), 32'd0);
        idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid",  32'(m_tvalid), 32'd1);
            check("bp_hold_data",   32'(m_tdata),  32'h4400);
            check("bp_hold_index",  32'(m_tindex), 32'd3);
            check("bp_hold_sready", 32'(s_tready), 32'd0);
        end
        @(posedge clk); #1;
        rdy_fix = 1'b1;
        wait_drain("drain_bp", 20);

        // Reset while a result is pending: it must vanish.
        rdy_fix = 1'b0;
        drive(pack4(16'h4000, 16'h3C00, 16'h3C00, 16'h3C00), 4'hF, 1'b1, w);
        idle();
        repeat (3) @(negedge clk);
        check("pending_before_rst", 32'(m_tvalid), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_result");
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_fix = 1'b1;
        repeat (3) @(negedge clk);
        check("no_result_after_rst", 32'(m_tvalid), 32'd0);
        @(posedge clk); #1;

        // Reset mid-packet, then a clean packet starting at index 0.
        drive(pack4(16'h7000, 16'h7000, 16'h7000, 16'h7000), 4'hF, 1'b0, w);
        drive(pack4(16'h7000, 16'h7000, 16'h7000, 16'h7000), 4'hF, 1'b0, w);
        idle();
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_packet");
        pk_val.delete();
        pk_keep.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_exp(16'h4800, 16'd2, 1'b0);
        drive(pack4(16'h3C00, 16'h4000, 16'h4800, 16'h4400), 4'hF, 1'b1, w);
        idle();
        wait_drain("drain_rst", 20);

        // Five beats through the 4-bit index instance: counter wraps, sticky flag set.
        ovf_en = 1'b1;
        push_exp(16'h5000, 16'd17, 1'b0);
        for (int b = 0; b < 4; b++)
            drive(pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00), 4'hF, 1'b0, w);
        drive(pack4(16'h3C00, 16'h5000, 16'h3C00, 16'h3C00), 4'hF, 1'b1, w);
        idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m2_tvalid) break;
        end
        check("ovf_valid", 32'(m2_tvalid), 32'd1);
        check("ovf_data",  32'(m2_tdata),  32'h5000);
        check("ovf_index", 32'(m2_tindex), 32'd1);
        check("ovf_flag",  32'(m2_tovf),   32'd1);
        check("ovf_ready", 32'(s2_tready), 32'd1);
        @(posedge clk); #1;
        push_exp(16'h4800, 16'd7, 1'b0);
        drive(pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00), 4'hF, 1'b0, w);
        drive(pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h4800), 4'hF, 1'b1, w);
        idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m2_tvalid) break;
        end
        check("ovf2_valid", 32'(m2_tvalid), 32'd1);
        check("ovf2_index", 32'(m2_tindex), 32'd7);
        check("ovf2_flag",  32'(m2_tovf),   32'd0);
        @(posedge clk); #1;
        ovf_en = 1'b0;
        wait_drain("drain_ovf", 20);

        // Random packets against the reference model with a randomly stalling sink.
        rand_mode = 1'b1;
        use_model = 1'b1;
        for (int p = 0; p < 12; p++) begin
            int nb;
            logic [63:0] d;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                for (int j = 0; j < LANES; j++) d[16*j +: 16] = rand_fp();
                drive(d, 4'($urandom_range(0, 15)), (b == nb - 1), w);
            end
        end
        idle();
        wait_drain("drain_random", 200);
        rand_mode = 1'b0;
        use_model = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
